// File: rtl/scaled_fx_pkg.sv
`default_nettype none
//==============================================================================
// Module : scaled_fx_pkg
// Shared definitions for the scaled fixed-point word {scale, mant}.
// Rev    : 1.0
//==============================================================================
package scaled_fx_pkg;

    localparam int c_mant_w  = 13;
    localparam int c_scale_w = 3;

    function automatic int max_scale(input int scale_w);
        return (1 << scale_w) - 1;
    endfunction

    // Room for the largest alignment shift plus one carry bit.
    function automatic int dp_width(input int mant_w, input int scale_w);
        return mant_w + max_scale(scale_w) + 2;
    endfunction

    // Field helpers operate on words of up to 32 bits.
    function automatic logic [31:0] word_scale(input logic [31:0] word, input int mant_w);
        return word >> mant_w;
    endfunction

    function automatic logic [31:0] word_mant(input logic [31:0] word, input int mant_w);
        return word & ((32'd1 << mant_w) - 32'd1);
    endfunction

    function automatic logic [31:0] sat_pos(input int mant_w);
        return (32'd1 << (mant_w - 1)) - 32'd1;
    endfunction

    function automatic logic [31:0] sat_neg(input int mant_w);
        return ~sat_pos(mant_w);
    endfunction

endpackage
`default_nettype wire

// File: rtl/scaled_add_sub_pipe_if.sv
`default_nettype none
//==============================================================================
// Module : scaled_add_sub_pipe_if
// Operand/result valid-ready bundle for the scaled add/sub pipeline.
// Rev    : 1.0
//==============================================================================
interface scaled_add_sub_pipe_if
    import scaled_fx_pkg::*;
#(
    parameter int MANT_W  = c_mant_w,
    parameter int SCALE_W = c_scale_w
);
    localparam int c_word_w = SCALE_W + MANT_W;

    logic                in_valid;
    logic                in_ready;
    logic [c_word_w-1:0] in_a;
    logic [c_word_w-1:0] in_b;
    logic                in_sub;
    logic                in_cin;
    logic                out_valid;
    logic                out_ready;
    logic [c_word_w-1:0] out_word;
    logic                out_overflow;
    logic                out_inexact;

    modport master (
        output in_valid, in_a, in_b, in_sub, in_cin, out_ready,
        input  in_ready, out_valid, out_word, out_overflow, out_inexact
    );

    modport slave (
        input  in_valid, in_a, in_b, in_sub, in_cin, out_ready,
        output in_ready, out_valid, out_word, out_overflow, out_inexact
    );

endinterface
`default_nettype wire

// File: rtl/scaled_normalize.sv
`default_nettype none
//==============================================================================
// Module : scaled_normalize
// Right-renormalises a wide sum into {scale, mant} with overflow handling.
// Rev    : 1.0
//==============================================================================
module scaled_normalize
    import scaled_fx_pkg::*;
#(
    parameter int W        = 22,
    parameter int MANT_W   = 13,
    parameter int SCALE_W  = 3,
    parameter int SAT_MODE = 1
) (
    input  logic signed [W-1:0]         i_r,
    input  logic [SCALE_W-1:0]          i_s_min,
    output logic [SCALE_W+MANT_W-1:0]   o_word,
    output logic                        o_overflow,
    output logic                        o_inexact
);
    localparam int                  c_max_scale = max_scale(SCALE_W);
    localparam int                  c_kmax      = W - MANT_W;
    localparam logic [W-1:0]        c_ones      = '1;
    localparam logic signed [W-1:0] c_lo        = W'(sat_neg(MANT_W));
    localparam logic signed [W-1:0] c_hi        = W'(sat_pos(MANT_W));

    int w_k;
    int w_new_scale;
    int w_wrap_sh;

    function automatic logic fits(input logic signed [W-1:0] v, input int k);
        return ((v >>> k) >= c_lo) && ((v >>> k) <= c_hi);
    endfunction

    always_comb begin
        // Descending scan leaves the smallest shift that fits.
        w_k = c_kmax;
        for (int k = c_kmax; k >= 0; k--) begin
            if (fits(i_r, k)) begin
                w_k = k;
            end
        end
        w_new_scale = int'(i_s_min) + w_k;
        w_wrap_sh   = c_max_scale - int'(i_s_min);
        o_word      = '0;
        o_overflow  = 1'b0;
        o_inexact   = 1'b0;
        if (w_new_scale <= c_max_scale) begin
            o_word    = {SCALE_W'(w_new_scale), MANT_W'(i_r >>> w_k)};
            o_inexact = |(i_r & ~(c_ones << w_k));
        end else if (SAT_MODE != 0) begin
            o_word     = {SCALE_W'(c_max_scale),
                          i_r[W-1] ? MANT_W'(sat_neg(MANT_W)) : MANT_W'(sat_pos(MANT_W))};
            o_overflow = 1'b1;
            o_inexact  = 1'b1;
        end else begin
            o_word     = {SCALE_W'(c_max_scale), MANT_W'(i_r >>> w_wrap_sh)};
            o_overflow = 1'b1;
            o_inexact  = |(i_r & ~(c_ones << w_wrap_sh));
        end
    end

endmodule
`default_nettype wire

// File: rtl/scaled_add_sub_pipe.sv
`default_nettype none
//==============================================================================
// Module : scaled_add_sub_pipe
// Three-stage stallable align / add / renormalise for scaled fixed-point words.
// Rev    : 1.0
//==============================================================================
module scaled_add_sub_pipe
    import scaled_fx_pkg::*;
#(
    parameter int MANT_W   = c_mant_w,
    parameter int SCALE_W  = c_scale_w,
    parameter int SAT_MODE = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    scaled_add_sub_pipe_if.slave bus
);
    localparam int c_w      = dp_width(MANT_W, SCALE_W);
    localparam int c_word_w = SCALE_W + MANT_W;

    logic [SCALE_W-1:0]  w_scale_a, w_scale_b, w_smin, w_diff;
    logic [MANT_W-1:0]   w_mant_a, w_mant_b;
    logic [c_w-1:0]      w_ext_a, w_ext_b, w_al_a, w_al_b;
    logic                w_adv;
    logic [c_word_w-1:0] w_norm_word;
    logic                w_norm_ovf, w_norm_inx;

    logic                r_v1, r_v2, r_v3;
    logic [c_w-1:0]      r_a1, r_b1, r_sum2;
    logic [SCALE_W-1:0]  r_smin1, r_smin2;
    logic                r_sub1, r_cin1;
    logic [c_word_w-1:0] r_word3;
    logic                r_ovf3, r_inx3;

    // The whole pipe moves in lockstep whenever the output slot can drain.
    assign w_adv        = !r_v3 || bus.out_ready;
    assign bus.in_ready = w_adv;

    always_comb begin
        w_scale_a = SCALE_W'(word_scale(32'(bus.in_a), MANT_W));
        w_scale_b = SCALE_W'(word_scale(32'(bus.in_b), MANT_W));
        w_mant_a  = MANT_W'(word_mant(32'(bus.in_a), MANT_W));
        w_mant_b  = MANT_W'(word_mant(32'(bus.in_b), MANT_W));
        w_ext_a   = {{(c_w-MANT_W){w_mant_a[MANT_W-1]}}, w_mant_a};
        w_ext_b   = {{(c_w-MANT_W){w_mant_b[MANT_W-1]}}, w_mant_b};
        if (w_scale_a >= w_scale_b) begin
            w_smin = w_scale_b;
            w_diff = w_scale_a - w_scale_b;
            w_al_a = w_ext_a << w_diff;
            w_al_b = w_ext_b;
        end else begin
            w_smin = w_scale_a;
            w_diff = w_scale_b - w_scale_a;
            w_al_a = w_ext_a;
            w_al_b = w_ext_b << w_diff;
        end
    end

    scaled_normalize #(
        .W        (c_w),
        .MANT_W   (MANT_W),
        .SCALE_W  (SCALE_W),
        .SAT_MODE (SAT_MODE)
    ) u_norm (
        .i_r        (r_sum2),
        .i_s_min    (r_smin2),
        .o_word     (w_norm_word),
        .o_overflow (w_norm_ovf),
        .o_inexact  (w_norm_inx)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_v1    <= 1'b0;
            r_v2    <= 1'b0;
            r_v3    <= 1'b0;
            r_word3 <= '0;
            r_ovf3  <= 1'b0;
            r_inx3  <= 1'b0;
        end else if (w_adv) begin
            r_v1    <= bus.in_valid;
            r_v2    <= r_v1;
            r_v3    <= r_v2;
            r_word3 <= w_norm_word;
            r_ovf3  <= w_norm_ovf;
            r_inx3  <= w_norm_inx;
        end
    end

    always_ff @(posedge clk) begin
        if (w_adv) begin
            r_a1    <= w_al_a;
            r_b1    <= w_al_b;
            r_smin1 <= w_smin;
            r_sub1  <= bus.in_sub;
            r_cin1  <= bus.in_cin;
            r_sum2  <= r_a1 + (r_sub1 ? -r_b1 : r_b1) + c_w'(r_cin1);
            r_smin2 <= r_smin1;
        end
    end

    assign bus.out_valid    = r_v3;
    assign bus.out_word     = r_word3;
    assign bus.out_overflow = r_ovf3;
    assign bus.out_inexact  = r_inx3;

endmodule
`default_nettype wire

// File: tb/tb_scaled_add_sub_pipe.sv
`default_nettype none
//==============================================================================
// Module : tb_scaled_add_sub_pipe
// Saturating and wrapping instances driven in lockstep against a value model.
// Rev    : 1.0
//==============================================================================
module tb_scaled_add_sub_pipe;

    localparam int MANT_W  = 13;
    localparam int SCALE_W = 3;
    localparam int WW      = MANT_W + SCALE_W;
    localparam int MAXS    = (1 << SCALE_W) - 1;
    localparam longint LIM = longint'(1) << (MANT_W - 1);

    typedef struct {
        logic [WW-1:0] w_s;
        logic          ovf_s;
        logic          inx_s;
        logic [WW-1:0] w_w;
        logic          ovf_w;
        logic          inx_w;
        int            acc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;

    exp_t          q[$];
    exp_t          nil = '{default: 0};
    int            n_chk = 0;
    int            n_fail = 0;
    int            n_acc = 0;
    int            n_pop = 0;
    int            cyc = 0;
    bit            lat_chk = 1'b0;
    bit            held_v = 1'b0;
    logic [WW-1:0] held_w;
    logic [1:0]    held_f;
    logic          last_rdy;
    logic          last_acc;

    always #5 clk = ~clk;

    scaled_add_sub_pipe_if #(.MANT_W(MANT_W), .SCALE_W(SCALE_W)) bus_s ();
    scaled_add_sub_pipe_if #(.MANT_W(MANT_W), .SCALE_W(SCALE_W)) bus_w ();

    assign bus_w.in_valid  = bus_s.in_valid;
    assign bus_w.in_a      = bus_s.in_a;
    assign bus_w.in_b      = bus_s.in_b;
    assign bus_w.in_sub    = bus_s.in_sub;
    assign bus_w.in_cin    = bus_s.in_cin;
    assign bus_w.out_ready = bus_s.out_ready;

    scaled_add_sub_pipe #(.MANT_W(MANT_W), .SCALE_W(SCALE_W), .SAT_MODE(1)) u_dut_sat (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_s)
    );

    scaled_add_sub_pipe #(.MANT_W(MANT_W), .SCALE_W(SCALE_W), .SAT_MODE(0)) u_dut_wrap (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_w)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] expv);
        n_chk++;
        if (got !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, expv, cyc);
        end
    endtask

    // Value-level reference: real operand values, floor division, range search.
    function automatic void model(input logic [WW-1:0] a, input logic [WW-1:0] b,
                                  input logic sub, input logic cin, input bit sat,
                                  output logic [WW-1:0] w, output logic ovf, output logic inx);
        logic [MANT_W-1:0] ma_bits, mb_bits;
        int     sa, sb, smin, k, sh;
        longint ma, mb, r, qv;
        sa      = int'(a[WW-1:MANT_W]);
        sb      = int'(b[WW-1:MANT_W]);
        ma_bits = a[MANT_W-1:0];
        mb_bits = b[MANT_W-1:0];
        ma      = longint'($signed(ma_bits));
        mb      = longint'($signed(mb_bits));
        smin    = (sa < sb) ? sa : sb;
        ma      = ma * (2 ** (sa - smin));
        mb      = mb * (2 ** (sb - smin));
        r       = sub ? (ma - mb) : (ma + mb);
        r       = r + (cin ? 1 : 0);
        k = 0;
        while ((r >>> k) > (LIM - 1) || (r >>> k) < -LIM) k++;
        if (smin + k <= MAXS) begin
            qv  = r >>> k;
            w   = {SCALE_W'(smin + k), MANT_W'(qv)};
            ovf = 1'b0;
            inx = (r != (qv <<< k));
        end else if (sat) begin
            w   = {SCALE_W'(MAXS), (r < 0) ? MANT_W'(-LIM) : MANT_W'(LIM - 1)};
            ovf = 1'b1;
            inx = 1'b1;
        end else begin
            sh  = MAXS - smin;
            qv  = r >>> sh;
            w   = {SCALE_W'(MAXS), MANT_W'(qv)};
            ovf = 1'b1;
            inx = (r != (qv <<< sh));
        end
    endfunction

    task automatic pop_check();
        exp_t e;
        if (q.size() == 0) begin
            check_eq("spurious_out", 32'(bus_s.out_valid), 0);
        end else begin
            e = q.pop_front();
            n_pop++;
            check_eq("word_sat",   32'(bus_s.out_word),     32'(e.w_s));
            check_eq("ovf_sat",    32'(bus_s.out_overflow), 32'(e.ovf_s));
            check_eq("inx_sat",    32'(bus_s.out_inexact),  32'(e.inx_s));
            check_eq("valid_wrap", 32'(bus_w.out_valid),    1);
            check_eq("word_wrap",  32'(bus_w.out_word),     32'(e.w_w));
            check_eq("ovf_wrap",   32'(bus_w.out_overflow), 32'(e.ovf_w));
            check_eq("inx_wrap",   32'(bus_w.out_inexact),  32'(e.inx_w));
            if (lat_chk) check_eq("latency", cyc - e.acc, 3);
        end
    endtask

    task automatic step(input logic v, input logic [WW-1:0] a, input logic [WW-1:0] b,
                        input logic sub, input logic cin, input logic ordy,
                        input bit use_dir, input exp_t d);
        exp_t          e;
        logic [WW-1:0] ws, wwr;
        logic          os, is_, ow, iw;
        if (held_v) begin
            check_eq("stall_valid", 32'(bus_s.out_valid), 1);
            check_eq("stall_word",  32'(bus_s.out_word), 32'(held_w));
            check_eq("stall_flags", 32'({bus_s.out_overflow, bus_s.out_inexact}), 32'(held_f));
        end
        bus_s.in_valid  = v;
        bus_s.in_a      = a;
        bus_s.in_b      = b;
        bus_s.in_sub    = sub;
        bus_s.in_cin    = cin;
        bus_s.out_ready = ordy;
        #1;
        last_rdy = bus_s.in_ready;
        last_acc = v && bus_s.in_ready;
        if (bus_s.out_valid && ordy) pop_check();
        held_v = bus_s.out_valid && !ordy;
        held_w = bus_s.out_word;
        held_f = {bus_s.out_overflow, bus_s.out_inexact};
        if (last_acc) begin
            if (use_dir) begin
                e = d;
            end else begin
                model(a, b, sub, cin, 1'b1, ws, os, is_);
                model(a, b, sub, cin, 1'b0, wwr, ow, iw);
                e.w_s = ws;  e.ovf_s = os; e.inx_s = is_;
                e.w_w = wwr; e.ovf_w = ow; e.inx_w = iw;
            end
            e.acc = cyc;
            q.push_back(e);
            n_acc++;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic rnd_step(input logic v, input logic ordy);
        logic [WW-1:0] a, b;
        a = WW'($urandom);
        b = WW'($urandom);
        step(v, a, b, 1'($urandom), 1'($urandom), ordy, 1'b0, nil);
    endtask

    task automatic dir_op(input logic [WW-1:0] a, input logic [WW-1:0] b, input logic sub,
                          input logic cin, input logic [WW-1:0] ws, input logic os,
                          input logic is_, input logic [WW-1:0] wwr, input logic ow,
                          input logic iw);
        exp_t d;
        d.w_s = ws;  d.ovf_s = os; d.inx_s = is_;
        d.w_w = wwr; d.ovf_w = ow; d.inx_w = iw;
        d.acc = 0;
        step(1'b1, a, b, sub, cin, 1'b1, 1'b1, d);
        check_eq("dir_accept", 32'(last_acc), 1);
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && q.size() != 0; i++) rnd_step(1'b0, 1'b1);
        check_eq("drain_empty", q.size(), 0);
    endtask

    initial begin
        int sent0, pop0;
        bit bp_seen;
        rst_n           = 1'b0;
        bus_s.in_valid  = 1'b0;
        bus_s.in_a      = '0;
        bus_s.in_b      = '0;
        bus_s.in_sub    = 1'b0;
        bus_s.in_cin    = 1'b0;
        bus_s.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_out_valid", 32'(bus_s.out_valid),    0);
        check_eq("rst_out_word",  32'(bus_s.out_word),     0);
        check_eq("rst_ovf",       32'(bus_s.out_overflow), 0);
        check_eq("rst_inx",       32'(bus_s.out_inexact),  0);
        check_eq("rst_word_wrap", 32'(bus_w.out_word),     0);
        check_eq("rst_in_ready",  32'(bus_s.in_ready),     1);
        rst_n = 1'b1;

        lat_chk = 1'b1;
        dir_op(16'h0064, 16'h0017, 1'b0, 1'b0, 16'h007B, 1'b0, 1'b0, 16'h007B, 1'b0, 1'b0);
        dir_op(16'h4005, 16'h0003, 1'b1, 1'b0, 16'h0011, 1'b0, 1'b0, 16'h0011, 1'b0, 1'b0);
        dir_op(16'h0003, 16'h4005, 1'b0, 1'b1, 16'h0018, 1'b0, 1'b0, 16'h0018, 1'b0, 1'b0);
        dir_op(16'h0FFF, 16'h0001, 1'b0, 1'b0, 16'h2800, 1'b0, 1'b0, 16'h2800, 1'b0, 1'b0);
        dir_op(16'h1000, 16'h0001, 1'b1, 1'b0, 16'h37FF, 1'b0, 1'b1, 16'h37FF, 1'b0, 1'b1);
        dir_op(16'hEFFF, 16'hEFFF, 1'b0, 1'b0, 16'hEFFF, 1'b1, 1'b1, 16'hFFFE, 1'b1, 1'b0);
        drain();

        for (int i = 0; i < 200; i++) rnd_step(1'b1, 1'b1);
        drain();
        lat_chk = 1'b0;

        for (int i = 0; i < 400; i++)
            rnd_step($urandom_range(0, 9) < 8, $urandom_range(0, 9) < 6);
        drain();

        sent0   = n_acc;
        pop0    = n_pop;
        bp_seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            rnd_step((n_acc - sent0) < 5, 1'b0);
            if (!last_rdy && !bp_seen) begin
                bp_seen = 1'b1;
                check_eq("bp_held", n_acc - n_pop, 3);
            end
        end
        check_eq("bp_ready_fell", 32'(bp_seen), 1);
        check_eq("bp_in_ready_low", 32'(bus_s.in_ready), 0);
        for (int i = 0; i < 40 && !((n_acc - sent0) == 5 && q.size() == 0); i++)
            rnd_step((n_acc - sent0) < 5, 1'b1);
        check_eq("bp_sent", n_acc - sent0, 5);
        check_eq("bp_drained", n_pop - pop0, 5);

        rnd_step(1'b1, 1'b1);
        rnd_step(1'b1, 1'b1);
        check_eq("rst_inflight", q.size(), 2);
        rst_n = 1'b0;
        rnd_step(1'b0, 1'b1);
        rst_n = 1'b1;
        q.delete();
        check_eq("midrst_out_valid", 32'(bus_s.out_valid), 0);
        bus_s.out_ready = 1'b0;
        #1;
        check_eq("midrst_in_ready", 32'(bus_s.in_ready), 1);
        for (int i = 0; i < 6; i++) begin
            rnd_step(1'b0, 1'b1);
            check_eq("midrst_quiet", 32'(bus_s.out_valid | bus_w.out_valid), 0);
        end
        for (int i = 0; i < 20; i++) rnd_step(1'b1, 1'b1);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
